alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter MUL_CYCLES, default 3, number of cycles the ALU is held for a multiply (legal range 1..15).
REQ-002 The block SHALL have parameter WIDTH, default 32, operand/result width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 req0_valid / req1_valid  input  1  requester N has an operation pending.
REQ-006 req0_ready / req1_ready  output  1  requester N accepted this cycle (valid&ready = handshake).
REQ-007 req0_op / req1_op  input  3  ALU opcode: 000 AND, 001 OR, 010 ADD, 100 SUB, 101 MUL, 110 SLT; 011/111 illegal.
REQ-008 req0_a, req0_b / req1_a, req1_b  input  WIDTH  operands.
REQ-009 resp0_valid / resp1_valid  output  1  one-cycle result pulse to requester N.
REQ-010 resp_data  output  WIDTH  registered result, shared by both requesters.
REQ-011 resp_zero  output  1  registered zero flag (result == 0).
REQ-012 resp_err  output  1  registered, set when the completed op was illegal.
REQ-013 alu_op  output  3;  alu_a, alu_b  output  WIDTH  operands driven to the shared ALU.
REQ-014 alu_out  input  WIDTH;  alu_zero  input  1  combinational ALU result and zero flag.
REQ-015 busy  output  1  high whenever state is not IDLE.

Function
REQ-016 FSM states SHALL be IDLE, EXEC, DONE.
REQ-017 In IDLE, the block SHALL assert at most one reqN_ready, combinationally, to a valid requester chosen round-robin; with both valid, the requester not granted last wins.
REQ-018 On handshake in IDLE, op/a/b of the winner SHALL be captured into internal registers, the grant index recorded, and state SHALL move to EXEC.
REQ-019 alu_op/alu_a/alu_b SHALL be driven only from the captured registers, never directly from request inputs; in IDLE they SHALL drive 000/0/0.
REQ-020 EXEC SHALL last 1 cycle for non-MUL ops and MUL_CYCLES cycles for MUL (101), counted by a down-counter loaded at handshake.
REQ-021 On the last EXEC cycle, alu_out and alu_zero SHALL be registered into resp_data and resp_zero, and state SHALL move to DONE.
REQ-022 Illegal ops (011, 111) SHALL take 1 EXEC cycle, complete with resp_data=0, resp_zero=1, resp_err=1, without relying on alu_out.
REQ-023 In DONE, the granted requester's respN_valid SHALL be high for exactly one cycle, last-grant pointer updated, and state SHALL return to IDLE.
REQ-024 Latency: handshake in cycle T -> respN_valid in cycle T+N+1 (N = EXEC length); back-to-back throughput one op per N+2 cycles.
REQ-025 reqN_ready SHALL be 0 in EXEC and DONE; request inputs changing then SHALL have no effect.
REQ-026 resp_data/resp_zero/resp_err SHALL hold their value until the next completion.
REQ-027 respN_valid SHALL never be asserted to a requester that did not win the handshake; resp0_valid and resp1_valid SHALL never be high together.

Reset
REQ-028 Asserting rst SHALL immediately force state IDLE, counter 0, captured registers 0, resp_data 0, resp_zero 0, resp_err 0, respN_valid 0, busy 0.
REQ-029 The last-grant pointer SHALL reset to requester 1, so requester 0 wins the first tie.
REQ-030 rst asserted mid-EXEC SHALL abort the operation with no response pulse issued.

Structure
REQ-031 Opcode constants (OP_AND, OP_OR, OP_ADD, OP_SUB, OP_MUL, OP_SLT) and the FSM state encoding SHALL live in a shared package used by the ALU, decoder and this block.
REQ-032 The round-robin grant logic SHALL be a sub-module rr_arb2 (inputs req[1:0], last; output grant[1:0]); the ALU itself SHALL be instantiated outside this block.

Verification
REQ-033 Req0 only, ADD a=5 b=7 -> req0_ready at T, resp0_valid at T+2, resp_data=12, resp_zero=0.
REQ-034 Both valid after reset, req0 SUB 9-9, req1 OR 0xF0|0x0F -> req0 served first (resp_data=0, resp_zero=1), then req1 (resp_data=0xFF).
REQ-035 Req1 MUL a=6 b=7, MUL_CYCLES=3 -> busy 4 cycles, resp1_valid at T+4, resp_data=42.
REQ-036 Req0 op 011 -> resp0_valid at T+2, resp_data=0, resp_zero=1, resp_err=1.
REQ-037 Both valid continuously for 4 ops -> grants alternate 0,1,0,1, never overlapping responses.
REQ-038 rst asserted during EXEC of MUL -> no resp pulse, all outputs 0 immediately, next request served normally.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// rtl/alu_arbiter_pkg.sv - shared opcodes, FSM encoding and opcode legality helper
package alu_arbiter_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_SLT = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // 011 and 111 are the only encodings outside the opcode set.
  function automatic logic op_is_legal(input logic [2:0] op);
    logic legal;
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_MUL, OP_SLT: legal = 1'b1;
      default:                                       legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// rtl/alu_arbiter_rr_arb2.sv - two-requester round-robin grant
// Ports:
//   req[1:0]   requests pending
//   last       index of the requester served most recently
//   grant[1:0] one-hot grant (or zero when nothing requests)
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  // On a tie the requester that was not served last wins.
  assign grant[0] = req[0] & (~req[1] | last);
  assign grant[1] = req[1] & (~req[0] | ~last);

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - arbitrates two requesters onto one shared external ALU
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   reqN_valid/op/a/b, reqN_ready request channel of requester N (N = 0, 1)
//   respN_valid                  one-cycle completion pulse to requester N
//   resp_data/resp_zero/resp_err registered result shared by both requesters
//   alu_op/alu_a/alu_b           operands to the external ALU
//   alu_out/alu_zero             combinational ALU result
//   busy                         high while an operation is in flight
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int MUL_CYCLES = 3,
  parameter int WIDTH      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             resp0_valid,
  output logic             resp1_valid,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_zero,
  output logic             resp_err,
  output logic [2:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero,
  output logic             busy
);

  // Counter holds "EXEC cycles remaining after this one".
  localparam logic [3:0] MUL_LAST = 4'(MUL_CYCLES - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [3:0]       r_cnt;
  logic             r_gnt_idx;
  logic             r_last;

  logic [1:0]       w_grant;
  logic             w_hs;
  logic [2:0]       w_sel_op;

  rr_arb2 u_rr_arb2 (
    .req   ({req1_valid, req0_valid}),
    .last  (r_last),
    .grant (w_grant)
  );

  // A grant is only produced for a valid requester, so grant in IDLE is the handshake.
  assign w_hs     = (r_state == ST_IDLE) && (w_grant != 2'b00);
  assign w_sel_op = w_grant[1] ? req1_op : req0_op;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    resp0_valid = 1'b0;
    resp1_valid = 1'b0;
    busy        = 1'b1;
    alu_op      = r_op;
    alu_a       = r_a;
    alu_b       = r_b;
    case (r_state)
      ST_IDLE: begin
        busy       = 1'b0;
        req0_ready = w_grant[0];
        req1_ready = w_grant[1];
        alu_op     = 3'b000;
        alu_a      = '0;
        alu_b      = '0;
        if (w_hs) w_state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        if (r_cnt == 4'd0) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        resp0_valid = ~r_gnt_idx;
        resp1_valid = r_gnt_idx;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        busy        = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op      <= 3'b000;
      r_a       <= '0;
      r_b       <= '0;
      r_cnt     <= 4'd0;
      r_gnt_idx <= 1'b0;
      r_last    <= 1'b1;
      resp_data <= '0;
      resp_zero <= 1'b0;
      resp_err  <= 1'b0;
    end else begin
      if (w_hs) begin
        r_gnt_idx <= w_grant[1];
        r_op      <= w_sel_op;
        r_a       <= w_grant[1] ? req1_a : req0_a;
        r_b       <= w_grant[1] ? req1_b : req0_b;
        r_cnt     <= (w_sel_op == OP_MUL) ? MUL_LAST : 4'd0;
      end else if (r_state == ST_EXEC && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end

      if (r_state == ST_EXEC && r_cnt == 4'd0) begin
        // Illegal opcodes complete with a fixed result; the ALU output is ignored.
        if (op_is_legal(r_op)) begin
          resp_data <= alu_out;
          resp_zero <= alu_zero;
          resp_err  <= 1'b0;
        end else begin
          resp_data <= '0;
          resp_zero <= 1'b1;
          resp_err  <= 1'b1;
        end
      end

      if (r_state == ST_DONE) r_last <= r_gnt_idx;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard bench for alu_arbiter with an external ALU stub
module tb_alu_arbiter;

  localparam int MULC = 3;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } stim_t;

  typedef struct {
    int          who;
    logic [31:0] data;
    logic        zero;
    logic        err;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [2:0]  req0_op = 3'b000, req1_op = 3'b000;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        resp0_valid, resp1_valid;
  logic [31:0] resp_data;
  logic        resp_zero, resp_err;
  logic [2:0]  alu_op;
  logic [31:0] alu_a, alu_b;
  logic [31:0] alu_out;
  logic        alu_zero;
  logic        busy;

  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;
  stim_t stim0[$];
  stim_t stim1[$];
  int    n_taken0 = 0;
  int    n_taken1 = 0;
  exp_t  exp_q[$];
  bit    gap_en = 1'b0;

  // reference model state
  int    m_busy_from = 0;
  int    m_free = 0;
  bit    m_last = 1'b1;

  alu_arbiter #(.MUL_CYCLES(MULC), .WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .resp0_valid(resp0_valid), .resp1_valid(resp1_valid),
    .resp_data(resp_data), .resp_zero(resp_zero), .resp_err(resp_err),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_zero(alu_zero), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] alu_calc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b100:  return a - b;
      3'b101:  return a * b;
      3'b110:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // External ALU stub; junk on illegal codes so the block must not rely on it.
  always_comb begin
    alu_out  = alu_calc(alu_op, alu_a, alu_b);
    alu_zero = (alu_out == 32'd0);
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at cycle %0d", name, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 4))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Driver: holds each request until it is taken, junk on idle inputs.
  always @(posedge clk) begin
    #1;
    if (n_taken0 < stim0.size()) begin
      if (!req0_valid) req0_valid = !gap_en || ($urandom_range(0, 2) != 0);
    end else req0_valid = 1'b0;
    if (req0_valid) {req0_op, req0_a, req0_b} = stim0[n_taken0];
    else {req0_op, req0_a, req0_b} = {3'($urandom), 32'($urandom), 32'($urandom)};
    if (n_taken1 < stim1.size()) begin
      if (!req1_valid) req1_valid = !gap_en || ($urandom_range(0, 2) != 0);
    end else req1_valid = 1'b0;
    if (req1_valid) {req1_op, req1_a, req1_b} = stim1[n_taken1];
    else {req1_op, req1_a, req1_b} = {3'($urandom), 32'($urandom), 32'($urandom)};
  end

  // Reference model: decides grants, busy window and pushes expected responses.
  always @(negedge clk) begin : model
    bit          w0, w1, free, bexp;
    logic [2:0]  op;
    logic [31:0] a, b, d;
    int          n;
    exp_t        e;
    if (rst) begin
      m_last = 1'b1;
      m_busy_from = 0;
      m_free = 0;
      exp_q.delete();
    end else begin
      free = (cyc >= m_free);
      bexp = (cyc >= m_busy_from) && (cyc < m_free);
      w0 = 1'b0;
      w1 = 1'b0;
      if (free) begin
        if (req0_valid && req1_valid) begin
          if (m_last) w0 = 1'b1; else w1 = 1'b1;
        end else if (req0_valid) w0 = 1'b1;
        else if (req1_valid) w1 = 1'b1;
      end
      check("req0_ready", 64'(req0_ready), 64'(w0));
      check("req1_ready", 64'(req1_ready), 64'(w1));
      check("busy", 64'(busy), 64'(bexp));
      if (!bexp) check("alu_idle", {29'd0, alu_op, alu_a ^ alu_b, 32'd0} | 64'(alu_a), 64'd0);
      if (w0 || w1) begin
        op = w1 ? req1_op : req0_op;
        a  = w1 ? req1_a : req0_a;
        b  = w1 ? req1_b : req0_b;
        n  = (op == 3'b101) ? MULC : 1;
        e.who = w1 ? 1 : 0;
        if (op == 3'b011 || op == 3'b111) begin
          e.data = 32'd0; e.zero = 1'b1; e.err = 1'b1;
        end else begin
          d = alu_calc(op, a, b);
          e.data = d; e.zero = (d == 32'd0); e.err = 1'b0;
        end
        e.due = cyc + n + 1;
        exp_q.push_back(e);
        m_busy_from = cyc + 1;
        m_free = cyc + n + 2;
        m_last = w1;
        if (w1) n_taken1++; else n_taken0++;
      end
    end
  end

  // Monitor: pops and compares on every response pulse, checks hold otherwise.
  always @(negedge clk) begin : monitor
    exp_t        e;
    logic [31:0] h_data;
    logic        h_zero, h_err;
    if (rst) begin
      h_data = '0; h_zero = 1'b0; h_err = 1'b0;
    end else if (resp0_valid || resp1_valid) begin
      check("resp_overlap", 64'(resp0_valid & resp1_valid), 64'd0);
      if (exp_q.size() == 0) begin
        check("resp_unexpected", 64'({resp1_valid, resp0_valid}), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("resp_who", 64'({resp1_valid, resp0_valid}), (e.who == 1) ? 64'd2 : 64'd1);
        check("resp_cycle", 64'(cyc), 64'(e.due));
        check("resp_data", 64'(resp_data), 64'(e.data));
        check("resp_zero", 64'(resp_zero), 64'(e.zero));
        check("resp_err", 64'(resp_err), 64'(e.err));
        h_data = e.data; h_zero = e.zero; h_err = e.err;
      end
    end else begin
      check("resp_hold", {31'd0, resp_data, resp_zero}, {31'd0, h_data, h_zero});
      check("resp_err_hold", 64'(resp_err), 64'(h_err));
    end
  end

  task automatic check_reset_outputs();
    check("rst_ready", 64'({req1_ready, req0_ready}), 64'd0);
    check("rst_resp_valid", 64'({resp1_valid, resp0_valid}), 64'd0);
    check("rst_resp_data", 64'(resp_data), 64'd0);
    check("rst_flags", 64'({resp_zero, resp_err}), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_alu", {29'd0, alu_op, 32'd0} | 64'(alu_a | alu_b), 64'd0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_reset_outputs();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while ((n_taken0 < stim0.size() || n_taken1 < stim1.size() || exp_q.size() != 0) && k < budget) begin
      @(posedge clk);
      k++;
    end
    if (k >= budget) check("drain_timeout", 64'd1, 64'd0);
    repeat (2) @(posedge clk);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 check_reset_outputs();
    @(negedge clk);
    rst = 1'b0;

    // single ADD on requester 0
    stim0.push_back({3'b010, 32'd5, 32'd7});
    drain(50);

    // tie straight after reset: requester 0 first
    do_reset();
    stim0.push_back({3'b100, 32'd9, 32'd9});
    stim1.push_back({3'b001, 32'h0000_00F0, 32'h0000_000F});
    drain(50);

    // multiply on requester 1, then illegal opcode on requester 0
    stim1.push_back({3'b101, 32'd6, 32'd7});
    drain(50);
    stim0.push_back({3'b011, 32'd3, 32'd4});
    drain(50);

    // both continuously valid: strict alternation
    for (int i = 0; i < 4; i++) begin
      stim0.push_back({3'b010, 32'(i), 32'd100});
      stim1.push_back({3'b000, 32'hFFFF_0000, 32'(i + 16)});
    end
    drain(100);

    // randomized traffic with gaps, all opcodes including illegal ones
    gap_en = 1'b1;
    for (int i = 0; i < 30; i++) begin
      stim0.push_back({3'($urandom_range(0, 7)), rnd_operand(), rnd_operand()});
      stim1.push_back({3'($urandom_range(0, 7)), rnd_operand(), rnd_operand()});
    end
    drain(2000);
    gap_en = 1'b0;

    // reset in the middle of a multiply aborts it silently
    stim1.push_back({3'b101, 32'd6, 32'd7});
    begin
      int k = 0;
      while (n_taken1 < stim1.size() && k < 50) begin
        @(posedge clk);
        k++;
      end
      if (k >= 50) check("mul_accept_timeout", 64'd1, 64'd0);
    end
    @(posedge clk);
    do_reset();
    repeat (4) @(posedge clk);
    stim0.push_back({3'b010, 32'd5, 32'd7});
    drain(50);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
